// File: rtl/div16_restoring.sv
// Sequential 16-bit unsigned restoring divider producing one quotient bit per clock.
// The trial subtraction each iteration runs through a 16-bit ripple subtractor.

module FullSubtractor16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    output logic [15:0] D,
    output logic        Borrow
);
    logic [16:0] bw;

    assign bw[0] = Bin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign D[i]    = A[i] ^ B[i] ^ bw[i];
        assign bw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bw[i]);
    end

    assign Borrow = bw[16];
endmodule

module div16_restoring (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    // Partial remainder is always below the divisor, so its 17th bit is never set between iterations.
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted_c;
    logic [WIDTH-1:0]   diff_c;
    logic               borrow_c;
    logic               trial_ok_c;
    logic [WIDTH-1:0]   q_next_c;
    logic [WIDTH-1:0]   r_next_c;

    assign shifted_c = {r_q, q_q[WIDTH-1]};

    FullSubtractor16bit u_sub (
        .A      (shifted_c[WIDTH-1:0]),
        .B      (dvs_q),
        .Bin    (1'b0),
        .D      (diff_c),
        .Borrow (borrow_c)
    );

    // A set 17th bit means the shifted remainder exceeds any 16-bit divisor.
    assign trial_ok_c = shifted_c[WIDTH] | ~borrow_c;
    assign q_next_c   = {q_q[WIDTH-2:0], trial_ok_c};
    assign r_next_c   = trial_ok_c ? diff_c : shifted_c[WIDTH-1:0];

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == WIDTH'(0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        q_d     = dividend;
                        r_d     = WIDTH'(0);
                        dvs_d   = divisor;
                        cnt_d   = CNT_W'(0);
                    end
                end
            end
            S_CALC: begin
                q_d   = q_next_c;
                r_d   = r_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quot_d  = q_next_c;
                    rem_d   = r_next_c;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div16_restoring.sv
// Self-checking bench for div16_restoring: directed scenarios plus randomized
// operands compared against a plain-arithmetic division model.

module tb_div16_restoring;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    div16_restoring dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned division, with the all-ones/dividend/flag rule for a zero divisor.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic z);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issues one start pulse from IDLE and waits (bounded) for done; lat counts
    // falling edges after the accepting edge, -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic z, output int lat, output logic busy_first);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        busy_first = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) busy_first = busy;
            if (done) begin
                lat = i;
                break;
            end
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dividend = 16'd0;
        divisor = 16'd0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (quotient !== 16'd0) begin n_fail++; $display("FAIL reset_quot got %h want 0", quotient); end
        if (remainder !== 16'd0) begin n_fail++; $display("FAIL reset_rem got %h want 0", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] q, r;
        logic z, bf;
        int lat;
        run_op(16'd100, 16'd7, q, r, z, lat, bf);
        n_checks += 5;
        if (bf !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", bf); end
        if (lat != 17) begin n_fail++; $display("FAIL basic_latency got %0d want 17", lat); end
        if (q !== 16'd14) begin n_fail++; $display("FAIL basic_quot got %0d want 14", q); end
        if (r !== 16'd2) begin n_fail++; $display("FAIL basic_rem got %0d want 2", r); end
        if (z !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %b want 0", z); end
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        if (quotient !== 16'd14) begin n_fail++; $display("FAIL basic_hold got %0d want 14", quotient); end
    endtask

    task automatic test_corners();
        logic [15:0] av [3];
        logic [15:0] bv [3];
        logic [15:0] qv [3];
        logic [15:0] rv [3];
        logic [15:0] q, r;
        logic z, bf;
        int lat;
        av = '{16'hFFFF, 16'hFFFF, 16'h8000};
        bv = '{16'h0003, 16'hFFFF, 16'hFFFF};
        qv = '{16'h5555, 16'h0001, 16'h0000};
        rv = '{16'h0000, 16'h0000, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], q, r, z, lat, bf);
            n_checks += 3;
            if (q !== qv[i]) begin n_fail++; $display("FAIL corner%0d_quot got %h want %h", i, q, qv[i]); end
            if (r !== rv[i]) begin n_fail++; $display("FAIL corner%0d_rem got %h want %h", i, r, rv[i]); end
            if (lat != 17) begin n_fail++; $display("FAIL corner%0d_latency got %0d want 17", i, lat); end
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] q, r;
        logic z, bf;
        int lat;
        run_op(16'h1234, 16'd0, q, r, z, lat, bf);
        n_checks += 4;
        if (lat < 1 || lat > 2) begin n_fail++; $display("FAIL dbz_latency got %0d want 1..2", lat); end
        if (q !== 16'hFFFF) begin n_fail++; $display("FAIL dbz_quot got %h want ffff", q); end
        if (r !== 16'h1234) begin n_fail++; $display("FAIL dbz_rem got %h want 1234", r); end
        if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", z); end
        run_op(16'd9, 16'd3, q, r, z, lat, bf);
        n_checks += 3;
        if (q !== 16'd3) begin n_fail++; $display("FAIL after_dbz_quot got %0d want 3", q); end
        if (r !== 16'd0) begin n_fail++; $display("FAIL after_dbz_rem got %0d want 0", r); end
        if (z !== 1'b0) begin n_fail++; $display("FAIL after_dbz_flag got %b want 0", z); end
    endtask

    task automatic test_start_while_busy();
        int dones;
        logic [15:0] q, r;
        q = 16'd0;
        r = 16'd0;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd1000;
        divisor = 16'd10;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                q = quotient;
                r = remainder;
            end
            if (i == 5 || i == 16) begin
                start = 1'b1;
                dividend = 16'd777;
                divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
        end
        n_checks += 3;
        if (dones != 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
        if (q !== 16'd100) begin n_fail++; $display("FAIL busy_start_quot got %0d want 100", q); end
        if (r !== 16'd0) begin n_fail++; $display("FAIL busy_start_rem got %0d want 0", r); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, r;
        logic z, bf;
        int lat;
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd500;
        divisor = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (quotient !== 16'd0) begin n_fail++; $display("FAIL midrst_quot got %h want 0", quotient); end
        if (remainder !== 16'd0) begin n_fail++; $display("FAIL midrst_rem got %h want 0", remainder); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd500, 16'd3, q, r, z, lat, bf);
        n_checks += 3;
        if (q !== 16'd166) begin n_fail++; $display("FAIL midrst_quot2 got %0d want 166", q); end
        if (r !== 16'd2) begin n_fail++; $display("FAIL midrst_rem2 got %0d want 2", r); end
        if (lat != 17) begin n_fail++; $display("FAIL midrst_latency got %0d want 17", lat); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int t0, t1;
        logic [15:0] q0, r0, q1, r1;
        dones = 0;
        t0 = 0; t1 = 0;
        q0 = 16'd0; r0 = 16'd0; q1 = 16'd0; r1 = 16'd0;
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd50;
        divisor = 16'd5;
        for (int i = 1; i <= 60 && dones < 2; i++) begin
            @(negedge clk);
            if (done) begin
                if (dones == 0) begin
                    t0 = i; q0 = quotient; r0 = remainder;
                    dividend = 16'd49;
                end else begin
                    t1 = i; q1 = quotient; r1 = remainder;
                    start = 1'b0;
                end
                dones++;
            end
        end
        start = 1'b0;
        n_checks += 6;
        if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", dones); end
        if (t1 - t0 != 18) begin n_fail++; $display("FAIL b2b_spacing got %0d want 18", t1 - t0); end
        if (q0 !== 16'd10) begin n_fail++; $display("FAIL b2b_quot0 got %0d want 10", q0); end
        if (r0 !== 16'd0) begin n_fail++; $display("FAIL b2b_rem0 got %0d want 0", r0); end
        if (q1 !== 16'd9) begin n_fail++; $display("FAIL b2b_quot1 got %0d want 9", q1); end
        if (r1 !== 16'd4) begin n_fail++; $display("FAIL b2b_rem1 got %0d want 4", r1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a, b, q, r, eq, er;
        logic z, ez, bf;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: b = 16'($urandom);
            endcase
            ref_div(a, b, eq, er, ez);
            run_op(a, b, q, r, z, lat, bf);
            n_checks += 4;
            if (q !== eq) begin n_fail++; $display("FAIL rand_quot %h/%h got %h want %h", a, b, q, eq); end
            if (r !== er) begin n_fail++; $display("FAIL rand_rem %h/%h got %h want %h", a, b, r, er); end
            if (z !== ez) begin n_fail++; $display("FAIL rand_dbz %h/%h got %b want %b", a, b, z, ez); end
            if (lat < 1) begin n_fail++; $display("FAIL rand_timeout %h/%h got %0d want done", a, b, lat); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_corners();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
